// File: rtl/prog_mem_pkg.sv
// Shared types for the program memory / loader block.
package prog_mem_pkg;

    localparam int PROG_DEPTH  = 64;
    localparam int PROG_ADDR_W = 6;

    // Physical fetch address {mode[1:0], addr[3:0]} and 8-bit instruction word
    typedef logic [PROG_ADDR_W-1:0] addr_t;
    typedef logic [7:0]             data_t;

    // Loader sequencing: halted, receiving a program, CPU released
    typedef enum logic [1:0] {
        HALT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/prog_mem_if.sv
// Bus between the program memory and its users: the CPU fetch port and the
// byte-stream loader.
//
// Loader handshake: a byte moves when load_valid && load_ready are both high
// at a rising clock edge. The loader raises load_valid with load_data and
// holds both unchanged until that edge; load_ready never depends on
// load_valid, so the loader may wait for it before asserting valid.
interface prog_mem_if;
    import prog_mem_pkg::*;

    addr_t       addr;        // CPU fetch address
    data_t       data;        // instruction word at addr (combinational)
    logic        load_start;  // one-cycle pulse: begin/restart a load
    logic        load_valid;  // loader byte valid
    logic [7:0]  load_data;   // loader byte
    logic        load_ready;  // byte accepted this cycle if valid
    logic        cpu_run;     // releases the CPU (its active-low reset)
    logic        load_done;   // one-cycle pulse after the final byte
    logic [7:0]  checksum;    // XOR of bytes accepted in current/last load

    modport master (
        output addr, load_start, load_valid, load_data,
        input  data, load_ready, cpu_run, load_done, checksum
    );

    modport slave (
        input  addr, load_start, load_valid, load_data,
        output data, load_ready, cpu_run, load_done, checksum
    );

endinterface

// File: rtl/prog_ram.sv
// Program storage: one synchronous write port, one asynchronous read port.
// Deliberately not reset so a program survives a reset of the loader.
module prog_ram
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DEPTH  = PROG_DEPTH
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  data_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output data_t             rdata
);

    data_t mem_q [DEPTH];

    // Write port: store the byte on the rising edge when enabled
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is purely combinational so fetches see writes next cycle
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_mem.sv
// Program memory with a serial loader. Holds the CPU in reset (cpu_run=0)
// while a program is streamed in byte by byte, then releases it once the
// last word is written. The read port stays live in every state.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DEPTH  = PROG_DEPTH
) (
    input  logic          clock,
    input  logic          reset,
    prog_mem_if.slave     bus,
    output loader_state_t dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state_q,     state_d;
    logic [ADDR_W-1:0] wptr_q,      wptr_d;
    logic [7:0]        csum_q,      csum_d;
    logic              cpu_run_q,   cpu_run_d;
    logic              load_done_q, load_done_d;
    logic              load_ready;
    logic              xfer;
    logic              ram_we;

    // A pending restart pulse blocks acceptance so the restart cycle never
    // writes a byte into the new load.
    assign load_ready = (state_q == LOAD) && !bus.load_start;
    assign xfer       = bus.load_valid && load_ready;
    // A cycle with reset asserted must not disturb memory
    assign ram_we     = xfer && !reset;

    // Next-state logic: sequencing, write pointer, running checksum
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        csum_d      = csum_q;
        load_done_d = 1'b0;
        case (state_q)
            HALT: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    csum_d  = '0;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    // Restart: rewind, earlier words stay in the array
                    wptr_d = '0;
                    csum_d = '0;
                end else if (xfer) begin
                    csum_d = csum_q ^ bus.load_data;
                    if (wptr_q == LAST_ADDR) begin
                        state_d     = RUN;
                        wptr_d      = '0;
                        load_done_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + ADDR_W'(1);
                    end
                end
            end
            RUN: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    csum_d  = '0;
                end
            end
            default: begin
                state_d = HALT;
                wptr_d  = '0;
                csum_d  = '0;
            end
        endcase
        // Registered so the CPU reset line is glitch-free and tracks state
        cpu_run_d = (state_d == RUN);
    end

    // State register with synchronous reset; reset wins over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HALT;
            wptr_q      <= '0;
            csum_q      <= '0;
            cpu_run_q   <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            csum_q      <= csum_d;
            cpu_run_q   <= cpu_run_d;
            load_done_q <= load_done_d;
        end
    end

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (bus.load_data),
        .raddr (ADDR_W'(bus.addr)),
        .rdata (bus.data)
    );

    assign bus.load_ready = load_ready;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.load_done  = load_done_q;
    assign bus.checksum   = csum_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: scripted scenarios plus a randomized
// load, all checked against a behavioural model of the loader.
module tb_prog_mem;
    import prog_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    prog_mem_if bus ();
    loader_state_t dbg_state;

    prog_mem #(.ADDR_W(6), .DEPTH(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    logic [7:0]    m_mem [64];
    bit            m_known [64];
    loader_state_t m_state = HALT;
    int            m_count = 0;      // bytes accepted in the current load
    logic [7:0]    exp_q [$];        // bytes accepted in current/last load

    // Expectations for the cycle just driven, captured before the edge
    bit         e_ready;
    bit         e_known;
    logic [7:0] e_data;
    logic       obs_ready;
    logic [7:0] obs_data;

    function automatic logic [7:0] exp_csum();
        logic [7:0] c = 8'h00;
        foreach (exp_q[i]) c = c ^ exp_q[i];
        return c;
    endfunction

    function automatic void model_step(bit rst, bit start, bit valid, logic [7:0] d);
        if (rst) begin
            m_state = HALT;
            m_count = 0;
            exp_q.delete();
        end else if (start) begin
            m_state = LOAD;
            m_count = 0;
            exp_q.delete();
        end else if (m_state == LOAD && valid) begin
            m_mem[m_count]   = d;
            m_known[m_count] = 1'b1;
            exp_q.push_back(d);
            m_count++;
            if (m_count == 64) begin
                m_state = RUN;
                m_count = 0;
            end
        end
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle at posedge+1, sample combinational outputs at +3,
    // then advance past the next edge and update the model.
    task automatic tick(input bit rst, input bit start, input bit valid,
                        input logic [7:0] d, input addr_t a);
        reset          = rst;
        bus.load_start = start;
        bus.load_valid = valid;
        bus.load_data  = d;
        bus.addr       = a;
        e_ready = (m_state == LOAD) && !start;
        e_known = m_known[a];
        e_data  = m_mem[a];
        #2;
        obs_ready = bus.load_ready;
        obs_data  = bus.data;
        @(posedge clock);
        #1;
        model_step(rst, start, valid, d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Reset held together with load_start/load_valid: reset must win
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 8'hAA, 6'd0);
        n_checks++;
        if (dbg_state !== HALT) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, HALT); end
        n_checks++;
        if ({bus.cpu_run, bus.load_done} !== 2'b00) begin n_fail++; $display("FAIL reset_run_done got=%b exp=00", {bus.cpu_run, bus.load_done}); end
        n_checks++;
        if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL reset_checksum got=%h exp=00", bus.checksum); end
        // HALT ignores load_valid
        tick(0, 0, 1, 8'h33, 6'd0);
        n_checks++;
        if (obs_ready !== 1'b0 || dbg_state !== HALT) begin n_fail++; $display("FAIL halt_ready got=%b/%0d exp=0/%0d", obs_ready, dbg_state, HALT); end
    endtask

    task automatic test_sequential_load();
        int rdy_bad = 0, done_bad = 0;
        tick(0, 1, 0, 8'h00, 6'd0);
        n_checks++;
        if (bus.cpu_run !== 1'b0 || dbg_state !== LOAD || bus.checksum !== 8'h00) begin
            n_fail++; $display("FAIL seq_enter got=run%b st%0d cs%h exp=run0 st%0d cs00", bus.cpu_run, dbg_state, bus.checksum, LOAD);
        end
        for (int i = 0; i < 64; i++) begin
            tick(0, 0, 1, 8'(i), 6'd0);
            if (obs_ready !== 1'b1) rdy_bad++;
            if (i < 63 && bus.load_done !== 1'b0) done_bad++;
        end
        n_checks++;
        if (rdy_bad !== 0) begin n_fail++; $display("FAIL seq_ready got=%0d_low_cycles exp=0", rdy_bad); end
        n_checks++;
        if (done_bad !== 0) begin n_fail++; $display("FAIL seq_early_done got=%0d exp=0", done_bad); end
        n_checks++;
        if (bus.load_done !== 1'b1 || bus.cpu_run !== 1'b1) begin n_fail++; $display("FAIL seq_done got=done%b run%b exp=11", bus.load_done, bus.cpu_run); end
        tick(0, 0, 0, 8'h00, 6'h2A);
        n_checks++;
        if (obs_data !== 8'h2A) begin n_fail++; $display("FAIL seq_read2a got=%h exp=2a", obs_data); end
        n_checks++;
        if (bus.load_done !== 1'b0 || bus.cpu_run !== 1'b1) begin n_fail++; $display("FAIL seq_done_pulse got=done%b run%b exp=01", bus.load_done, bus.cpu_run); end
        n_checks++;
        if (bus.checksum !== 8'h00 || bus.checksum !== exp_csum()) begin n_fail++; $display("FAIL seq_checksum got=%h exp=%h", bus.checksum, exp_csum()); end
    endtask

    task automatic test_toggle_valid();
        int  cycles = 0, rdy_bad = 0, data_bad = 0;
        bit  done = 1'b0;
        tick(0, 1, 0, 8'h00, 6'd0);
        while (!done && cycles < 200) begin
            tick(0, 0, cycles[0], 8'hA5, addr_t'($urandom_range(0, 63)));
            cycles++;
            if (obs_ready !== e_ready) rdy_bad++;
            if (e_known && obs_data !== e_data) data_bad++;
            if (bus.load_done === 1'b1) done = 1'b1;
        end
        n_checks++;
        if (!done || cycles !== 128) begin n_fail++; $display("FAIL toggle_cycles got=%0d exp=128", cycles); end
        n_checks++;
        if (rdy_bad !== 0 || data_bad !== 0) begin n_fail++; $display("FAIL toggle_ready_data got=%0d/%0d exp=0/0", rdy_bad, data_bad); end
        n_checks++;
        if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL toggle_checksum got=%h exp=00", bus.checksum); end
        data_bad = 0;
        for (int a = 0; a < 64; a++) begin
            tick(0, 0, 0, 8'h00, addr_t'(a));
            if (obs_data !== 8'hA5 || obs_data !== e_data) data_bad++;
        end
        n_checks++;
        if (data_bad !== 0) begin n_fail++; $display("FAIL toggle_mem got=%0d_bad_words exp=0", data_bad); end
    endtask

    task automatic test_restart();
        int done_at = -1, data_bad = 0;
        tick(0, 1, 0, 8'h00, 6'd0);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 8'($urandom_range(0, 254)), 6'd0);
        // Restart together with a valid byte: nothing is accepted
        tick(0, 1, 1, 8'hFF, 6'd0);
        n_checks++;
        if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL restart_ready got=%b exp=0", obs_ready); end
        n_checks++;
        if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL restart_checksum got=%h exp=00", bus.checksum); end
        for (int i = 0; i < 64; i++) begin
            tick(0, 0, 1, 8'hFF, 6'd0);
            if (bus.load_done === 1'b1 && done_at < 0) done_at = i;
        end
        n_checks++;
        if (done_at !== 63) begin n_fail++; $display("FAIL restart_done_index got=%0d exp=63", done_at); end
        n_checks++;
        if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL restart_final_cs got=%h exp=00", bus.checksum); end
        for (int a = 0; a < 64; a++) begin
            tick(0, 0, 0, 8'h00, addr_t'(a));
            if (obs_data !== 8'hFF) data_bad++;
        end
        n_checks++;
        if (data_bad !== 0) begin n_fail++; $display("FAIL restart_mem got=%0d_bad_words exp=0", data_bad); end
    endtask

    task automatic test_run_restart();
        int rdy_bad = 0, data_bad = 0;
        // Bytes offered while running must be ignored
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 8'h55, addr_t'(i));
            if (obs_ready !== 1'b0 || bus.cpu_run !== 1'b1) rdy_bad++;
        end
        n_checks++;
        if (rdy_bad !== 0) begin n_fail++; $display("FAIL run_ignore got=%0d_bad_cycles exp=0", rdy_bad); end
        tick(0, 1, 1, 8'h55, 6'd0);
        n_checks++;
        if (obs_ready !== 1'b0 || bus.cpu_run !== 1'b0 || dbg_state !== LOAD) begin
            n_fail++; $display("FAIL run_restart got=rdy%b run%b st%0d exp=rdy0 run0 st%0d", obs_ready, bus.cpu_run, dbg_state, LOAD);
        end
        tick(0, 0, 0, 8'h00, 6'd0);
        n_checks++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready_rise got=%b exp=1", obs_ready); end
        for (int a = 0; a < 4; a++) begin
            tick(0, 0, 0, 8'h00, addr_t'(a));
            if (obs_data !== 8'hFF) data_bad++;
        end
        n_checks++;
        if (data_bad !== 0) begin n_fail++; $display("FAIL run_no_write got=%0d_bad_words exp=0", data_bad); end
    endtask

    task automatic test_reset_midload();
        int data_bad = 0;
        // Still in LOAD with nothing accepted; write 20 fresh bytes
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 8'($urandom_range(0, 254)), 6'd0);
        tick(1, 0, 1, 8'h00, 6'd0);
        n_checks++;
        if (dbg_state !== HALT || bus.cpu_run !== 1'b0 || bus.checksum !== 8'h00 || bus.load_done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_regs got=st%0d run%b cs%h done%b exp=st%0d run0 cs00 done0", dbg_state, bus.cpu_run, bus.checksum, bus.load_done, HALT);
        end
        for (int a = 0; a < 64; a++) begin
            tick(0, 0, 0, 8'h00, addr_t'(a));
            if (obs_data !== e_data || (a >= 20 && obs_data !== 8'hFF)) data_bad++;
        end
        n_checks++;
        if (data_bad !== 0) begin n_fail++; $display("FAIL midreset_mem got=%0d_bad_words exp=0", data_bad); end
        n_checks++;
        if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got=%b exp=0", obs_ready); end
    endtask

    task automatic test_start_and_valid();
        tick(0, 1, 0, 8'h00, 6'd0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 8'(8'h10 + i), 6'd0);
        tick(0, 1, 1, 8'h77, 6'd3);
        n_checks++;
        if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL sv_ready got=%b exp=0", obs_ready); end
        tick(0, 0, 0, 8'h00, 6'd3);
        n_checks++;
        if (obs_data !== e_data) begin n_fail++; $display("FAIL sv_no_write got=%h exp=%h", obs_data, e_data); end
        // The next accepted byte must land at word 0
        tick(0, 0, 1, 8'h99, 6'd0);
        tick(0, 0, 0, 8'h00, 6'd0);
        n_checks++;
        if (obs_data !== 8'h99) begin n_fail++; $display("FAIL sv_wptr_zero got=%h exp=99", obs_data); end
        tick(0, 0, 0, 8'h00, 6'd1);
        n_checks++;
        if (obs_data !== 8'h11) begin n_fail++; $display("FAIL sv_word1 got=%h exp=11", obs_data); end
    endtask

    task automatic test_random_load();
        int  cycles = 0, rdy_bad = 0, data_bad = 0;
        bit  done = 1'b0;
        tick(0, 1, 0, 8'h00, 6'd0);
        while (!done && cycles < 600) begin
            tick(0, 0, 1'($urandom_range(0, 1)), 8'($urandom), addr_t'($urandom_range(0, 63)));
            cycles++;
            if (obs_ready !== e_ready) rdy_bad++;
            if (e_known && obs_data !== e_data) data_bad++;
            if (bus.load_done === 1'b1) done = 1'b1;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rand_timeout got=%0d_cycles exp=done", cycles); end
        n_checks++;
        if (rdy_bad !== 0 || data_bad !== 0) begin n_fail++; $display("FAIL rand_ready_data got=%0d/%0d exp=0/0", rdy_bad, data_bad); end
        n_checks++;
        if (bus.checksum !== exp_csum() || bus.cpu_run !== 1'b1) begin n_fail++; $display("FAIL rand_checksum got=%h run%b exp=%h run1", bus.checksum, bus.cpu_run, exp_csum()); end
        data_bad = 0;
        for (int a = 0; a < 64; a++) begin
            tick(0, 0, 0, 8'h00, addr_t'(a));
            if (obs_data !== e_data) data_bad++;
        end
        n_checks++;
        if (data_bad !== 0) begin n_fail++; $display("FAIL rand_mem got=%0d_bad_words exp=0", data_bad); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset          = 1'b1;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.addr       = '0;
        test_reset();
        test_sequential_load();
        test_toggle_valid();
        test_restart();
        test_run_restart();
        test_reset_midload();
        test_start_and_valid();
        test_random_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_W, default 6, sets the physical address width ({mode[1:0], addr[3:0]}).
REQ-002 Parameter DEPTH, default 64 (2**ADDR_W), sets the number of 8-bit program words.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port addr  input  addr_t  CPU fetch address (physical view, 6 bits).
REQ-006 Port data  output  data_t  instruction word {opcode[3:0], imm[3:0]} at addr.
REQ-007 Port load_start  input  1  one-cycle pulse; begins a program load.
REQ-008 Port load_valid  input  1  loader byte valid.
REQ-009 Port load_data  input  8  loader byte.
REQ-010 Port load_ready  output  1  block accepts the byte this cycle.
REQ-011 Port cpu_run  output  1  high releases the CPU; drives the CPU's active-low reset directly.
REQ-012 Port load_done  output  1  one-cycle pulse after the final byte is accepted.
REQ-013 Port checksum  output  8  XOR of all bytes accepted in the current or most recent load.

Function
REQ-014 The read path is combinational: data equals mem[addr] in the same cycle, in every state.
REQ-015 During loading, data shall return the array content at addr, including bytes written earlier in the same load.
REQ-016 FSM states are HALT, LOAD and RUN, encoded in the shared enum.
REQ-017 In HALT, cpu_run=0 and load_ready=0; load_start moves to LOAD.
REQ-018 On entry to LOAD:
- write pointer wptr=0;
- checksum=0;
- cpu_run=0 from the same edge.
REQ-019 load_ready = (state==LOAD) && !load_start, a combinational function of these two terms only.
REQ-020 A transfer occurs when load_valid && load_ready; on that edge:
- mem[wptr] <= load_data;
- wptr <= wptr+1;
- checksum <= checksum ^ load_data.
REQ-021 When the transfer at wptr==DEPTH-1 occurs:
- state -> RUN;
- wptr wraps to 0;
- load_done pulses high for the next cycle only;
- cpu_run=1 from that next cycle.
REQ-022 In RUN, cpu_run=1, load_ready=0, and load_valid is ignored.
REQ-023 load_start in LOAD restarts the load: wptr=0, checksum=0, no byte accepted that cycle, and already-written words are retained.
REQ-024 load_start in RUN moves to LOAD and deasserts cpu_run on the same edge.
REQ-025 load_valid without load_ready has no effect; the loader holds load_data until it is accepted.
REQ-026 load_done is registered and never asserts outside the cycle after the final transfer.

Reset
REQ-027 Reset forces:
- state=HALT, wptr=0, checksum=0;
- cpu_run=0, load_done=0, load_ready=0.
REQ-028 Reset shall not modify mem contents; a reset mid-load leaves partially written words in place.
REQ-029 Reset has priority over load_start and load_valid in the same cycle.

Structure
REQ-030 The following belong in the shared types package:
- addr_t and data_t, already defined there;
- the FSM enum loader_state_t {HALT, LOAD, RUN};
- the constant PROG_DEPTH=64.
REQ-031 The storage array is a sub-module prog_ram: one synchronous write port and one asynchronous read port, with no reset.
REQ-032 The FSM, wptr, checksum and handshake logic reside in prog_mem.

Verification
REQ-033 Reset, then load_start, then 64 bytes 0x00..0x3F back-to-back:
- load_ready stays high throughout;
- load_done pulses 1 cycle after byte 0x3F;
- cpu_run=1 thereafter;
- checksum=0x00;
- addr=0x2A reads data=0x2A.
REQ-034 Load with load_valid toggling every other cycle: 64 accepted bytes take 128 cycles; pattern 0xA5 repeated gives checksum=0x00, and mem is correct.
REQ-035 load_start asserted at wptr=10, then 64 bytes 0xFF: ten cycles earlier no byte is accepted on the restart cycle; final checksum=0x00; all words read 0xFF.
REQ-036 In RUN, pulse load_start: cpu_run falls on the same edge and load_ready rises the next cycle; bytes presented in RUN before the pulse are not written.
REQ-037 Reset asserted at wptr=20:
- state=HALT, cpu_run=0, checksum=0;
- words 0..19 retain the new values;
- words 20..63 retain the old values.
REQ-038 load_start and load_valid in the same LOAD cycle: load_ready=0, no write occurs, and wptr=0 afterwards.
